// File: rtl/vec_fxp_to_fp_if.sv
// Vector handshake bundle for the fixed-point to minifloat encoder.
// master = upstream/downstream driver side, slave = encoder side.
interface vec_fxp_to_fp_if #(
   parameter int exp_width = 5,
   parameter int man_width = 2,
   parameter int length    = 32
);
   localparam int bit_width = 1 + exp_width + man_width;
   localparam int prd_width = 2 * ((1 << exp_width) + man_width);

   logic                               i_valid;
   logic                               o_ready;
   logic [length-1:0][prd_width-1:0]   i_vec;
   logic                               o_valid;
   logic                               i_ready;
   logic [length-1:0][bit_width-1:0]   o_vec;

   modport master (
      output i_valid, i_vec, i_ready,
      input  o_ready, o_valid, o_vec
   );

   modport slave (
      input  i_valid, i_vec, i_ready,
      output o_ready, o_valid, o_vec
   );
endinterface

// File: rtl/vec_fxp_to_fp.sv
// Three-stage vector encoder: signed fixed-point lanes -> packed
// {sign, exp, man} minifloat with round-to-nearest-even, subnormals and
// saturation to max finite. All stages advance together on en.
module vec_fxp_to_fp #(
   parameter int exp_width = 5,
   parameter int man_width = 2,
   parameter int length    = 32
) (
   input logic              i_clk,
   input logic              i_rst,
   vec_fxp_to_fp_if.slave   bus
);
   localparam int bit_width  = 1 + exp_width + man_width;
   localparam int prd_width  = 2 * ((1 << exp_width) + man_width);
   localparam int bias       = (1 << (exp_width - 1)) - 1;
   localparam int frac_width = 2 * (bias - 1 + man_width);
   localparam int p_width    = $clog2(prd_width);
   // leading-one index at and above which the result is a normal number
   localparam int norm_min_p = frac_width + 1 - bias;
   // right shift that maps the input onto the subnormal quantum
   localparam int sub_shift  = frac_width + 1 - bias - man_width;
   localparam int low_width  = sub_shift + man_width;
   localparam int exp_max    = (1 << exp_width) - 2;

   logic en;
   logic v1, v2, v3;

   logic [length-1:0]                   sign_c, s1_sign, s2_sign, s2_zero, zero_c;
   logic [length-1:0][prd_width-1:0]    mag_c, s1_mag;
   logic [length-1:0][p_width-1:0]      p_c, s2_p;
   logic [length-1:0][prd_width-2:0]    frac_c, s2_frac;
   logic [length-1:0][low_width-1:0]    s2_low;
   logic [length-1:0][bit_width-1:0]    word_c, s3_word;

   assign en          = ~v3 | bus.i_ready;
   assign bus.o_ready = en;
   assign bus.o_valid = v3;
   assign bus.o_vec   = s3_word;

   // S1: split each lane into sign and unsigned magnitude (most negative
   // value becomes 2^(prd_width-1), which fits as unsigned)
   always_comb begin
      sign_c = '0;
      mag_c  = '0;
      for (int l = 0; l < length; l++) begin
         sign_c[l] = bus.i_vec[l][prd_width-1];
         mag_c[l]  = bus.i_vec[l][prd_width-1] ? (~bus.i_vec[l] + prd_width'(1))
                                               : bus.i_vec[l];
      end
   end

   // S2: priority-encode the leading one and left-align the magnitude below it
   always_comb begin
      p_c    = '0;
      zero_c = '0;
      frac_c = '0;
      for (int l = 0; l < length; l++) begin
         zero_c[l] = (s1_mag[l] == '0);
         for (int b = 0; b < prd_width; b++) begin
            if (s1_mag[l][b]) p_c[l] = p_width'(b);
         end
         frac_c[l] = (prd_width-1)'(s1_mag[l] << (p_width'(prd_width - 1) - p_c[l]));
      end
   end

   // S3: round to nearest even, handle subnormal range and saturate
   always_comb begin
      logic [man_width-1:0] man_t;
      logic                 grd;
      logic                 stk;
      logic                 rnd;
      logic [man_width:0]   man_r;
      int                   bexp;
      word_c = '0;
      for (int l = 0; l < length; l++) begin
         man_t = '0;
         grd   = 1'b0;
         stk   = 1'b0;
         rnd   = 1'b0;
         man_r = '0;
         bexp  = 0;
         if (s2_zero[l]) begin
            word_c[l] = '0;
         end else if (int'(s2_p[l]) >= norm_min_p) begin
            man_t = s2_frac[l][prd_width-2 -: man_width];
            grd   = s2_frac[l][prd_width-2-man_width];
            stk   = |s2_frac[l][prd_width-3-man_width:0];
            rnd   = grd & (stk | man_t[0]);
            man_r = {1'b0, man_t} + {{man_width{1'b0}}, rnd};
            // a mantissa carry leaves man_r's low bits at zero, bumping the exponent
            bexp  = int'(s2_p[l]) - frac_width + bias + int'(man_r[man_width]);
            if (bexp > exp_max)
               word_c[l] = {s2_sign[l], exp_width'(exp_max), {man_width{1'b1}}};
            else
               word_c[l] = {s2_sign[l], exp_width'(bexp), man_r[man_width-1:0]};
         end else begin
            man_t = s2_low[l][sub_shift +: man_width];
            grd   = s2_low[l][sub_shift-1];
            stk   = |s2_low[l][sub_shift-2:0];
            rnd   = grd & (stk | man_t[0]);
            man_r = {1'b0, man_t} + {{man_width{1'b0}}, rnd};
            // rounding out of the top subnormal lands on exp=1, man=0
            word_c[l] = {s2_sign[l], exp_width'(man_r[man_width]), man_r[man_width-1:0]};
         end
      end
   end

   // Pipeline registers; everything, bubbles included, holds while stalled
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         s1_sign <= '0;
         s1_mag  <= '0;
         s2_sign <= '0;
         s2_zero <= '0;
         s2_p    <= '0;
         s2_frac <= '0;
         s2_low  <= '0;
         s3_word <= '0;
      end else if (en) begin
         v1      <= bus.i_valid;
         s1_sign <= sign_c;
         s1_mag  <= mag_c;
         v2      <= v1;
         s2_sign <= s1_sign;
         s2_zero <= zero_c;
         s2_p    <= p_c;
         s2_frac <= frac_c;
         for (int l = 0; l < length; l++) s2_low[l] <= s1_mag[l][low_width-1:0];
         v3      <= v2;
         s3_word <= word_c;
      end
   end
endmodule

// File: tb/tb_vec_fxp_to_fp.sv
// Self-checking bench for vec_fxp_to_fp (E5M2, 32 lanes).
module tb_vec_fxp_to_fp;
   localparam int EW   = 5;
   localparam int MW   = 2;
   localparam int LEN  = 32;
   localparam int BW   = 1 + EW + MW;
   localparam int PW   = 2 * ((1 << EW) + MW);
   localparam int BIAS = (1 << (EW - 1)) - 1;
   localparam int FRAC = 2 * (BIAS - 1 + MW);

   typedef logic [LEN-1:0][PW-1:0] vin_t;
   typedef logic [LEN-1:0][BW-1:0] vout_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_cmp = 0;

   always #5 clk = ~clk;

   vec_fxp_to_fp_if #(.exp_width(EW), .man_width(MW), .length(LEN)) bus ();

   vec_fxp_to_fp #(.exp_width(EW), .man_width(MW), .length(LEN)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Reference: pick the quantum from the value's binade (or the subnormal
   // quantum), divide, round half to even on the remainder, then encode.
   function automatic logic [BW-1:0] ref_lane(input logic [PW-1:0] x);
      logic        sgn;
      logic [PW:0] mag, q, rem, half, quantum;
      int          msb, e, qe, k, n, ex, m;
      sgn = x[PW-1];
      mag = sgn ? (~{x[PW-1], x} + (PW+1)'(1)) : {1'b0, x};
      if (mag == '0) return '0;
      msb = 0;
      for (int b = 0; b <= PW; b++) if (mag[b]) msb = b;
      e  = msb - FRAC;
      qe = (e < 1 - BIAS) ? (1 - BIAS - MW) : (e - MW);
      k  = qe + FRAC;
      quantum = (PW+1)'(1) << k;
      q    = mag >> k;
      rem  = mag & (quantum - (PW+1)'(1));
      half = quantum >> 1;
      if (rem > half || (rem == half && q[0])) q = q + (PW+1)'(1);
      n = int'(q);
      if (e < 1 - BIAS) begin
         ex = (n >= (1 << MW)) ? 1 : 0;
         m  = n % (1 << MW);
      end else begin
         if (n == (2 << MW)) begin
            e = e + 1;
            n = 1 << MW;
         end
         ex = e + BIAS;
         m  = n - (1 << MW);
         if (ex > (1 << EW) - 2) begin
            ex = (1 << EW) - 2;
            m  = (1 << MW) - 1;
         end
      end
      return {sgn, ex[EW-1:0], m[MW-1:0]};
   endfunction

   function automatic vout_t ref_vec(input vin_t v);
      vout_t r;
      for (int l = 0; l < LEN; l++) r[l] = ref_lane(v[l]);
      return r;
   endfunction

   function automatic logic [PW-1:0] rand_lane();
      logic [95:0]   t;
      logic [PW-1:0] r;
      t = {$urandom(), $urandom(), $urandom()};
      r = t[PW-1:0];
      r = r >> $urandom_range(PW-1, 0);
      if ($urandom_range(1, 0) == 1) r = -r;
      return r;
   endfunction

   function automatic vin_t rand_vec();
      vin_t v;
      for (int l = 0; l < LEN; l++) v[l] = rand_lane();
      return v;
   endfunction

   // Stimulus only: present one vector at posedge+1 with an empty pipeline,
   // report the result and the number of edges until o_valid.
   task automatic send_one(input vin_t v, output vout_t got, output int lat, output bit ok);
      bus.i_vec   = v;
      bus.i_valid = 1'b1;
      bus.i_ready = 1'b1;
      lat = 0;
      ok  = 1'b0;
      got = '0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         lat++;
         bus.i_valid = 1'b0;
         if (bus.o_valid) begin
            got = bus.o_vec;
            ok  = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      bus.i_vec   = '0;
      #12;
      n_cmp++;
      if (bus.o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_o_valid: got %b want 0", bus.o_valid);
      end
      n_cmp++;
      if (bus.o_vec !== '0) begin
         n_err++;
         $display("FAIL reset_o_vec: got %h want 0", bus.o_vec);
      end
      n_cmp++;
      if (bus.o_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_o_ready: got %b want 1", bus.o_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [PW-1:0] dv [16];
      logic [BW-1:0] de [16];
      vin_t  v;
      vout_t got, expv;
      int    lat;
      bit    ok;
      dv[0]  = PW'(1) << 32;              de[0]  = 8'h3C;
      dv[1]  = PW'(5) << 30;              de[1]  = 8'h3D;
      dv[2]  = PW'(3) << 31;              de[2]  = 8'h3E;
      dv[3]  = -(PW'(3) << 31);           de[3]  = 8'hBE;
      dv[4]  = PW'(9) << 29;              de[4]  = 8'h3C;
      dv[5]  = PW'(11) << 29;             de[5]  = 8'h3E;
      dv[6]  = (PW'(9) << 29) + PW'(1);   de[6]  = 8'h3D;
      dv[7]  = PW'(1) << 52;              de[7]  = 8'h7B;
      dv[8]  = -(PW'(1) << 52);           de[8]  = 8'hFB;
      dv[9]  = PW'(15) << 44;             de[9]  = 8'h7B;
      dv[10] = PW'(1) << (PW-1);          de[10] = 8'hFB;
      dv[11] = PW'(1) << 16;              de[11] = 8'h01;
      dv[12] = PW'(1) << 15;              de[12] = 8'h00;
      dv[13] = PW'(3) << 15;              de[13] = 8'h02;
      dv[14] = -(PW'(1) << 14);           de[14] = 8'h80;
      dv[15] = '0;                        de[15] = 8'h00;
      for (int i = 0; i < 16; i++) begin
         v    = rand_vec();
         v[0] = dv[i];
         expv = ref_vec(v);
         send_one(v, got, lat, ok);
         n_vec++;
         n_cmp++;
         if (!ok) begin
            n_err++;
            $display("FAIL directed_timeout[%0d]: no o_valid within 20 cycles", i);
         end else begin
            n_cmp++;
            if (lat !== 3) begin
               n_err++;
               $display("FAIL directed_latency[%0d]: got %0d want 3", i, lat);
            end
            n_cmp++;
            if (got[0] !== de[i]) begin
               n_err++;
               $display("FAIL directed_lane0[%0d]: in %h got %h want %h", i, dv[i], got[0], de[i]);
            end
            n_cmp++;
            if (got !== expv) begin
               n_err++;
               for (int l = 0; l < LEN; l++)
                  if (got[l] !== expv[l])
                     $display("FAIL directed_lane[%0d][%0d]: in %h got %h want %h",
                              i, l, v[l], got[l], expv[l]);
            end
         end
      end
   endtask

   // mode 0: i_ready 1,0,0 repeating, i_valid held high
   // mode 1: random i_valid and i_ready
   // mode 2: full throughput, i_valid and i_ready always high
   task automatic test_stream(input int mode, input int nvec);
      vout_t expq[$];
      vout_t expv, prev_vec;
      vin_t  cur;
      bit    prev_stall, pend;
      int    sent, rcvd, cyc;
      sent = 0;
      rcvd = 0;
      cyc  = 0;
      prev_stall = 1'b0;
      prev_vec   = '0;
      pend = 1'b0;
      cur  = rand_vec();
      while (rcvd < nvec && cyc < 400) begin
         case (mode)
            0:       bus.i_ready = (cyc % 3 == 0);
            1:       bus.i_ready = ($urandom_range(1, 0) == 1);
            default: bus.i_ready = 1'b1;
         endcase
         if (!pend && sent < nvec)
            pend = (mode != 1) || ($urandom_range(3, 0) != 0);
         bus.i_valid = pend;
         bus.i_vec   = cur;
         #4;
         n_cmp++;
         if (bus.o_ready !== !(bus.o_valid && !bus.i_ready)) begin
            n_err++;
            $display("FAIL stream%0d_o_ready: cyc %0d got %b with o_valid %b i_ready %b",
                     mode, cyc, bus.o_ready, bus.o_valid, bus.i_ready);
         end
         if (prev_stall) begin
            n_cmp++;
            if (bus.o_valid !== 1'b1 || bus.o_vec !== prev_vec) begin
               n_err++;
               $display("FAIL stream%0d_stall_hold: cyc %0d o_valid %b, o_vec changed %b",
                        mode, cyc, bus.o_valid, bus.o_vec !== prev_vec);
            end
         end
         if (bus.o_valid && bus.i_ready) begin
            n_cmp++;
            if (expq.size() == 0) begin
               n_err++;
               $display("FAIL stream%0d_spurious: cyc %0d output with nothing outstanding", mode, cyc);
            end else begin
               expv = expq.pop_front();
               n_cmp++;
               if (bus.o_vec !== expv) begin
                  n_err++;
                  $display("FAIL stream%0d_data: out %0d got %h want %h", mode, rcvd, bus.o_vec, expv);
               end
               rcvd++;
            end
         end
         prev_stall = bus.o_valid && !bus.i_ready;
         prev_vec   = bus.o_vec;
         if (bus.i_valid && bus.o_ready) begin
            expq.push_back(ref_vec(cur));
            sent++;
            n_vec++;
            cur  = rand_vec();
            pend = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      n_cmp++;
      if (rcvd != nvec || expq.size() != 0) begin
         n_err++;
         $display("FAIL stream%0d_count: received %0d of %0d, %0d left", mode, rcvd, nvec, expq.size());
      end
      if (mode == 2) begin
         n_cmp++;
         if (cyc != nvec + 3) begin
            n_err++;
            $display("FAIL stream%0d_throughput: took %0d cycles want %0d", mode, cyc, nvec + 3);
         end
      end
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream%0d_extra_output: cyc %0d after drain o_valid %b", mode, c, bus.o_valid);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_in_flight();
      vin_t  v;
      vout_t got, expv;
      int    lat;
      bit    ok;
      bus.i_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.i_valid = 1'b1;
         bus.i_vec   = rand_vec();
         n_vec++;
         @(posedge clk);
         #1;
      end
      bus.i_valid = 1'b0;
      n_cmp++;
      if (bus.o_valid !== 1'b1) begin
         n_err++;
         $display("FAIL flight_o_valid_before_reset: got %b want 1", bus.o_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_valid !== 1'b0 || bus.o_vec !== '0) begin
         n_err++;
         $display("FAIL flight_async_clear: o_valid %b o_vec %h want 0/0", bus.o_valid, bus.o_vec);
      end
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flight_stale_output: cyc %0d o_valid %b", c, bus.o_valid);
         end
      end
      v    = rand_vec();
      expv = ref_vec(v);
      send_one(v, got, lat, ok);
      n_vec++;
      n_cmp++;
      if (!ok || lat !== 3 || got !== expv) begin
         n_err++;
         $display("FAIL flight_after_reset: ok %b latency %0d want 3, got %h want %h",
                  ok, lat, got, expv);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stream(0, 6);
      test_stream(1, 40);
      test_stream(2, 20);
      test_reset_in_flight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
      $fatal(1);
   end
endmodule
